// File: rtl/exc_pc_ctrl_if.sv
// exc_pc_ctrl_if
//   Vector-table read bus between the exception/next-PC controller and memory.
//   mem_addr   byte address of the vector entry (valid while mem_rd=1)
//   mem_rd     read request
//   mem_rdata  read data returned by memory
//   master: controller side, slave: memory side.
interface exc_pc_ctrl_if #(
    parameter int DATA_W = 32
) ();
    logic [DATA_W-1:0] mem_addr;
    logic              mem_rd;
    logic [DATA_W-1:0] mem_rdata;

    modport master (output mem_addr, output mem_rd, input  mem_rdata);
    modport slave  (input  mem_addr, input  mem_rd, output mem_rdata);
endinterface

// File: rtl/exc_pc_ctrl.sv
// exc_pc_ctrl
//   Exception / next-PC controller for the multicycle CPU. In normal operation
//   the PCSource value and the control unit's write enable pass straight to the
//   PC register. When an exception is requested, EPC and the one-hot cause are
//   recorded, the handler byte is fetched from the vector table, and the
//   zero-extended byte is loaded into PC while busy freezes the control unit.
// Ports
//   clk, reset      rising-edge clock, synchronous active-high reset
//   exc_req         exception request flags (bit 0 highest priority)
//   pc_in           current PC, already incremented past the faulting instr
//   pc_source_in    normal next PC
//   pc_write_in     normal PC write enable
//   mem             vector-table read bus (master side)
//   epc, cause      exception PC and one-hot cause of last accepted exception
//   pc_out, pc_load value and write enable for the PC register
//   busy            exception sequence in progress
module exc_pc_ctrl #(
    parameter int DATA_W   = 32,
    parameter int N_CAUSES = 3,
    parameter int VEC_BASE = 253,
    parameter int MEM_LAT  = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_CAUSES-1:0] exc_req,
    input  logic [DATA_W-1:0]   pc_in,
    input  logic [DATA_W-1:0]   pc_source_in,
    input  logic                pc_write_in,
    exc_pc_ctrl_if.master       mem,
    output logic [DATA_W-1:0]   epc,
    output logic [N_CAUSES-1:0] cause,
    output logic [DATA_W-1:0]   pc_out,
    output logic                pc_load,
    output logic                busy
);

    localparam int IDX_W = (N_CAUSES > 1) ? $clog2(N_CAUSES) : 1;
    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        LOAD
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   epc_q;
    logic [N_CAUSES-1:0] cause_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [DATA_W-1:0]   vec_q;
    logic [IDX_W-1:0]    idx_q;

    logic [IDX_W-1:0]    sel_idx;
    logic [N_CAUSES-1:0] sel_onehot;
    logic                req_any;
    logic                rd_last;

    // Only the low byte of the vector entry is used.
    logic unused_rdata_hi;
    assign unused_rdata_hi = ^mem.mem_rdata[DATA_W-1:8];

    assign req_any = |exc_req;
    assign rd_last = (cnt_q == CNT_W'(MEM_LAT - 1));

    // Scan from the top down so the lowest set bit is the final assignment.
    always_comb begin
        sel_idx    = '0;
        sel_onehot = '0;
        for (int unsigned i = 0; i < N_CAUSES; i++) begin
            if (exc_req[N_CAUSES-1-i]) begin
                sel_idx = IDX_W'(N_CAUSES - 1 - i);
            end
        end
        sel_onehot[sel_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            epc_q   <= '0;
            cause_q <= '0;
            cnt_q   <= '0;
            vec_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                IDLE: begin
                    if (req_any) begin
                        epc_q   <= pc_in - DATA_W'(4);
                        cause_q <= sel_onehot;
                        idx_q   <= sel_idx;
                        cnt_q   <= '0;
                    end
                end
                RD: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (rd_last) begin
                        vec_q <= DATA_W'(mem.mem_rdata[7:0]);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_out       = pc_source_in;
        pc_load      = pc_write_in;
        busy         = 1'b0;
        mem.mem_rd   = 1'b0;
        mem.mem_addr = DATA_W'(VEC_BASE) + DATA_W'(idx_q);
        unique case (state_q)
            IDLE: begin
                if (req_any) state_d = RD;
            end
            RD: begin
                mem.mem_rd = 1'b1;
                pc_load    = 1'b0;
                busy       = 1'b1;
                if (rd_last) state_d = LOAD;
            end
            LOAD: begin
                pc_out  = vec_q;
                pc_load = 1'b1;
                busy    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign epc   = epc_q;
    assign cause = cause_q;

endmodule

// File: tb/tb_exc_pc_ctrl.sv
module tb_exc_pc_ctrl;

    logic        clk;
    logic        reset;
    logic [31:0] pc_in;
    logic [31:0] pc_source_in;
    logic        pc_write_in;

    logic [2:0]  exc_a, exc_b;
    logic [31:0] epc_a, epc_b, pco_a, pco_b;
    logic [2:0]  cause_a, cause_b;
    logic        pcl_a, pcl_b, busy_a, busy_b;

    int n_cmp;
    int n_err;

    exc_pc_ctrl_if #(.DATA_W(32)) ifa ();
    exc_pc_ctrl_if #(.DATA_W(32)) ifb ();

    exc_pc_ctrl #(.DATA_W(32), .N_CAUSES(3), .VEC_BASE(253), .MEM_LAT(1)) u_lat1 (
        .clk(clk), .reset(reset), .exc_req(exc_a), .pc_in(pc_in),
        .pc_source_in(pc_source_in), .pc_write_in(pc_write_in), .mem(ifa),
        .epc(epc_a), .cause(cause_a), .pc_out(pco_a), .pc_load(pcl_a), .busy(busy_a)
    );

    exc_pc_ctrl #(.DATA_W(32), .N_CAUSES(3), .VEC_BASE(253), .MEM_LAT(3)) u_lat3 (
        .clk(clk), .reset(reset), .exc_req(exc_b), .pc_in(pc_in),
        .pc_source_in(pc_source_in), .pc_write_in(pc_write_in), .mem(ifb),
        .epc(epc_b), .cause(cause_b), .pc_out(pco_b), .pc_load(pcl_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge, then let inputs/outputs settle away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        exc_a = '0;
        exc_b = '0;
        pc_in = '0;
        pc_source_in = '0;
        pc_write_in  = 1'b0;
        ifa.mem_rdata = '0;
        ifb.mem_rdata = '0;
        tick();
        tick();
        reset = 1'b0;

        // 1: reset state and pass-through
        pc_source_in = 32'h40;
        pc_write_in  = 1'b1;
        #1;
        chk("rst_pc_out",  pco_a,  32'h40);
        chk("rst_pc_load", pcl_a,  1);
        chk("rst_busy",    busy_a, 0);
        chk("rst_mem_rd",  ifa.mem_rd, 0);
        chk("rst_epc",     epc_a,  0);
        chk("rst_cause",   cause_a, 0);
        chk("rst_b_pcout", pco_b,  32'h40);

        // 2: MEM_LAT=1, overflow exception
        pc_in = 32'h24;
        exc_a = 3'b010;
        ifa.mem_rdata = 32'h0000_00A7;
        tick();
        exc_a = '0;
        #1;
        chk("t2_rd",      ifa.mem_rd, 1);
        chk("t2_addr",    ifa.mem_addr, 254);
        chk("t2_busy",    busy_a, 1);
        chk("t2_pcl_rd",  pcl_a, 0);
        chk("t2_epc",     epc_a, 32'h20);
        chk("t2_cause",   cause_a, 3'b010);
        tick();
        chk("t2_pc_out",  pco_a, 32'hA7);
        chk("t2_pcl",     pcl_a, 1);
        chk("t2_ld_rd",   ifa.mem_rd, 0);
        tick();
        chk("t2_idle_busy", busy_a, 0);
        chk("t2_idle_pco",  pco_a, 32'h40);
        chk("t2_epc_hold",  epc_a, 32'h20);
        pc_write_in = 1'b0;
        #1;
        chk("t2_pwr0",      pcl_a, 0);

        // 3: priority
        exc_a = 3'b110;
        tick();
        exc_a = '0;
        #1;
        chk("t3a_addr",  ifa.mem_addr, 254);
        chk("t3a_cause", cause_a, 3'b010);
        tick();
        tick();
        pc_in = 32'h100;
        exc_a = 3'b101;
        tick();
        exc_a = '0;
        #1;
        chk("t3b_addr",  ifa.mem_addr, 253);
        chk("t3b_cause", cause_a, 3'b001);
        chk("t3b_epc",   epc_a, 32'hFC);
        tick();
        tick();

        // 4: MEM_LAT=3, byte truncation
        pc_in = 32'h80;
        exc_b = 3'b100;
        ifb.mem_rdata = 32'hFFFF_FF12;
        tick();
        exc_b = '0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("t4_rd%0d", k),   ifb.mem_rd, 1);
            chk($sformatf("t4_addr%0d", k), ifb.mem_addr, 255);
            chk($sformatf("t4_pcl%0d", k),  pcl_b, 0);
            tick();
        end
        chk("t4_pc_out", pco_b, 32'h12);
        chk("t4_pcl",    pcl_b, 1);
        chk("t4_ld_rd",  ifb.mem_rd, 0);
        tick();
        chk("t4_idle_busy", busy_b, 0);

        // 5: request during RD ignored, held request accepted after LOAD
        pc_in = 32'h200;
        exc_b = 3'b100;
        tick();
        exc_b = 3'b001;
        pc_in = 32'h300;
        tick();
        chk("t5_cause_hold", cause_b, 3'b100);
        chk("t5_epc_hold",   epc_b, 32'h1FC);
        chk("t5_addr",       ifb.mem_addr, 255);
        tick();
        tick();
        chk("t5_pcl",        pcl_b, 1);
        chk("t5_cause_ld",   cause_b, 3'b100);
        tick();
        chk("t5_idle_busy",  busy_b, 0);
        tick();
        chk("t5_new_addr",   ifb.mem_addr, 253);
        chk("t5_new_cause",  cause_b, 3'b001);
        chk("t5_new_epc",    epc_b, 32'h2FC);
        chk("t5_new_busy",   busy_b, 1);
        exc_b = '0;
        tick();
        tick();
        tick();
        tick();

        // 6: reset during RD, then wrap-around EPC
        pc_in = 32'h50;
        exc_a = 3'b001;
        tick();
        exc_a = '0;
        #1;
        chk("t6_rd_pre", ifa.mem_rd, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("t6_busy",   busy_a, 0);
        chk("t6_mem_rd", ifa.mem_rd, 0);
        chk("t6_epc",    epc_a, 0);
        chk("t6_cause",  cause_a, 0);
        chk("t6_pcl",    pcl_a, 0);
        tick();
        chk("t6_pcl2",   pcl_a, 0);
        chk("t6_busy2",  busy_a, 0);

        pc_in = 32'h0;
        exc_a = 3'b100;
        tick();
        exc_a = '0;
        #1;
        chk("t6_epc_wrap",  epc_a, 32'hFFFF_FFFC);
        chk("t6_cause_w",   cause_a, 3'b100);
        chk("t6_addr_w",    ifa.mem_addr, 255);
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
